demux1to3_stream: RTL

//  Steers one input word stream to one of three output channels (A/B/C) selected per word by a 2-bit select.

---
 rtl/demux1to3_stream_if.sv | 32 +++
 rtl/demux1to3_stream.sv | 92 +++++++++
 2 files changed

// File: rtl/demux1to3_stream_if.sv
// Stream bundle for the 1-to-3 demux: one input stream, three
// buffered output channels, plus illegal-select status.
interface demux1to3_stream_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [WIDTH-1:0] out_a_data;
    logic [WIDTH-1:0] out_b_data;
    logic [WIDTH-1:0] out_c_data;
    logic             bad_sel;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid,
        input  out_a_data, out_b_data, out_c_data,
        input  bad_sel, drop_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid,
        output out_a_data, out_b_data, out_c_data,
        output bad_sel, drop_cnt
    );
endinterface

// File: rtl/demux1to3_stream.sv
// Routes one word stream to channel A/B/C by a 2-bit select; each
// channel is a 1-entry registered buffer, sel==3 words are dropped.
module demux1to3_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    demux1to3_stream_if.slave bus
);
    typedef enum logic {EMPTY, FULL} ch_state_e;

    ch_state_e        state_q [3];
    ch_state_e        state_d [3];
    logic [WIDTH-1:0] data_q  [3];
    logic [2:0]       vld;
    logic [2:0]       sel_oh;
    logic [2:0]       acc_ch;
    logic [2:0]       fire;
    logic             illegal;
    logic             accept;
    logic             drop;
    logic             bad_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        sel_oh  = 3'b000;
        illegal = 1'b0;
        unique case (bus.in_sel)
            2'd0:    sel_oh = 3'b001;
            2'd1:    sel_oh = 3'b010;
            2'd2:    sel_oh = 3'b100;
            default: illegal = 1'b1;
        endcase
    end

    // Full buffer still accepts when its consumer drains it this cycle.
    assign bus.in_ready = illegal
                        | (|(sel_oh & (~vld | bus.out_ready)));
    assign accept = bus.in_valid & bus.in_ready;
    assign acc_ch = sel_oh & {3{accept}};
    assign drop   = accept & illegal;
    assign fire   = vld & bus.out_ready;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                EMPTY: if (acc_ch[i]) state_d[i] = FULL;
                FULL:  if (fire[i] && !acc_ch[i]) state_d[i] = EMPTY;
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                if (acc_ch[i]) data_q[i] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            bad_q <= drop;
            if (drop && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            vld[i] = (state_q[i] == FULL);
    end

    assign bus.out_valid  = vld;
    assign bus.out_a_data = data_q[0];
    assign bus.out_b_data = data_q[1];
    assign bus.out_c_data = data_q[2];
    assign bus.bad_sel    = bad_q;
    assign bus.drop_cnt   = cnt_q;
endmodule
